// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_pkg
// Purpose  : Shared constants and result record for the registered adder.
// Revision : 1.0 - initial release
// ============================================================================
package full_adder_pkg;

  // Operand width used when the integrator does not override WIDTH.
  localparam int DEFAULT_WIDTH = 1;

  // Widest sum the result record can carry; narrower sums are zero-extended.
  localparam int MAX_WIDTH = 32;

  // One registered adder result: carry-out, signed overflow and sum bits.
  typedef struct packed {
    logic                 c_out;
    logic                 ovf;
    logic [MAX_WIDTH-1:0] s;
  } result_t;

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_cell
// Purpose  : 1-bit combinational full adder, the ripple-chain building block.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  // Sum is the parity of the three inputs; carry is generate or propagate.
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/full_adder_unit.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_unit
// Purpose  : WIDTH-bit ripple-carry adder with registered sum, carry-out and
//            signed overflow, one cycle of latency, one result per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  // carry[i] enters bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic             ovf_comb;

  assign carry[0] = c_in;

  // One cell per bit with the carry rippling from LSB to MSB.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a     (a[i]),
        .b     (b[i]),
        .c_in  (carry[i]),
        .s     (sum_comb[i]),
        .c_out (carry[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the MSB differs from carry out of it.
  // For WIDTH = 1 the carry into the MSB is c_in itself.
  assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

  // Output registers: load on valid input, otherwise hold; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s     <= sum_comb;
        c_out <= carry[WIDTH];
        ovf   <= ovf_comb;
      end
    end
  end

endmodule : full_adder_unit
`default_nettype wire

// File: tb/tb_full_adder_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_adder_unit
// Purpose  : Self-checking bench for full_adder_unit at WIDTH = 1, 4 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_adder_unit;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // WIDTH = 1 instance
  logic       v1, c1, ov1, co1, of1;
  logic [0:0] a1, b1, s1;
  // WIDTH = 4 instance
  logic       v4, c4, ov4, co4, of4;
  logic [3:0] a4, b4, s4;
  // WIDTH = 8 instance
  logic       v8, c8, ov8, co8, of8;
  logic [7:0] a8, b8, s8;

  full_adder_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c_in(c1),
    .out_valid(ov1), .s(s1), .c_out(co1), .ovf(of1)
  );
  full_adder_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c_in(c4),
    .out_valid(ov4), .s(s4), .c_out(co4), .ovf(of4)
  );
  full_adder_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c_in(c8),
    .out_valid(ov8), .s(s8), .c_out(co8), .ovf(of8)
  );

  int checks   = 0;
  int failures = 0;

  result_t sb_q[$];     // expected results, pushed at drive, popped at output
  result_t held [3];    // last loaded result per instance (for hold checks)

  typedef struct {
    int         w;
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_s;
    logic       exp_co;
    logic       exp_ovf;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference adder: plain integer addition, overflow from operand/result signs.
  function automatic result_t model(int w, logic [7:0] a, logic [7:0] b, logic c);
    result_t    r;
    logic [8:0] sum;
    logic [8:0] mask;
    mask    = (9'd1 << w) - 9'd1;
    sum     = {1'b0, a & mask[7:0]} + {1'b0, b & mask[7:0]} + {8'd0, c};
    r       = '0;
    r.s     = 32'(sum[7:0] & mask[7:0]);
    r.c_out = sum[w];
    r.ovf   = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
    return r;
  endfunction

  function automatic int idx_of(int w);
    return (w == 1) ? 0 : (w == 4) ? 1 : 2;
  endfunction

  task automatic check_out(int w, logic exp_v, result_t e, string nm);
    logic        ov, co, of;
    logic [31:0] s;
    case (w)
      1:       begin ov = ov1; s = 32'(s1); co = co1; of = of1; end
      4:       begin ov = ov4; s = 32'(s4); co = co4; of = of4; end
      default: begin ov = ov8; s = 32'(s8); co = co8; of = of8; end
    endcase
    chk({nm, ".out_valid"}, 32'(ov), 32'(exp_v));
    chk({nm, ".s"},         s,       e.s);
    chk({nm, ".c_out"},     32'(co), 32'(e.c_out));
    chk({nm, ".ovf"},       32'(of), 32'(e.ovf));
  endtask

  // Drive one cycle on instance w (others idle), then check after the edge.
  task automatic apply(int w, logic v, logic [7:0] a, logic [7:0] b, logic c,
                       result_t e, string nm);
    result_t got;
    logic    exp_v;
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    case (w)
      1:       begin v1 = v; a1 = a[0:0]; b1 = b[0:0]; c1 = c; end
      4:       begin v4 = v; a4 = a[3:0]; b4 = b[3:0]; c4 = c; end
      default: begin v8 = v; a8 = a;      b8 = b;      c8 = c; end
    endcase
    if (v && !rst) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      for (int k = 0; k < 3; k++) held[k] = '0;
      got   = '0;
      exp_v = 1'b0;
    end else if (v) begin
      exp_v = 1'b1;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s.scoreboard actual=empty required=entry", nm);
        got = '0;
      end else begin
        got = sb_q.pop_front();
      end
      held[idx_of(w)] = got;
    end else begin
      exp_v = 1'b0;
      got   = held[idx_of(w)];
    end
    check_out(w, exp_v, got, nm);
  endtask

  function automatic vec_t mk(int w, logic v, logic [7:0] a, logic [7:0] b, logic c,
                              logic [7:0] es, logic eco, logic eov, string nm);
    vec_t t;
    t.w = w; t.v = v; t.a = a; t.b = b; t.c = c;
    t.exp_s = es; t.exp_co = eco; t.exp_ovf = eov; t.nm = nm;
    return t;
  endfunction

  initial begin
    result_t e;
    logic    rv, rc;
    logic [7:0] ra, rb;

    // ---------------- vector table (expected values written out by hand)
    //                w  v  a      b      c  s      co ovf
    vecs.push_back(mk(1, 1, 8'h0, 8'h0, 0, 8'h0, 0, 0, "w1_000"));
    vecs.push_back(mk(1, 1, 8'h0, 8'h0, 1, 8'h1, 0, 1, "w1_001"));
    vecs.push_back(mk(1, 1, 8'h0, 8'h1, 0, 8'h1, 0, 0, "w1_010"));
    vecs.push_back(mk(1, 1, 8'h0, 8'h1, 1, 8'h0, 1, 0, "w1_011"));
    vecs.push_back(mk(1, 1, 8'h1, 8'h0, 0, 8'h1, 0, 0, "w1_100"));
    vecs.push_back(mk(1, 1, 8'h1, 8'h0, 1, 8'h0, 1, 0, "w1_101"));
    vecs.push_back(mk(1, 1, 8'h1, 8'h1, 0, 8'h0, 1, 1, "w1_110"));
    vecs.push_back(mk(1, 1, 8'h1, 8'h1, 1, 8'h1, 1, 0, "w1_111"));
    vecs.push_back(mk(4, 1, 8'hF, 8'h1, 0, 8'h0, 1, 0, "w4_F+1"));
    vecs.push_back(mk(4, 1, 8'h7, 8'h1, 0, 8'h8, 0, 1, "w4_7+1"));
    vecs.push_back(mk(4, 1, 8'h8, 8'h8, 1, 8'h1, 1, 1, "w4_8+8+1"));
    vecs.push_back(mk(4, 1, 8'h3, 8'h4, 0, 8'h7, 0, 0, "w4_3+4"));
    vecs.push_back(mk(4, 0, 8'hF, 8'hF, 1, 8'h0, 0, 0, "w4_hold"));
    vecs.push_back(mk(4, 0, 8'hF, 8'hF, 0, 8'h0, 0, 0, "w4_hold2"));
    vecs.push_back(mk(8, 1, 8'h7F, 8'h01, 0, 8'h80, 0, 1, "w8_7F+1"));
    vecs.push_back(mk(8, 1, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0, "w8_FF+FF+1"));
    vecs.push_back(mk(4, 1, 8'h5, 8'h5, 0, 8'hA, 0, 1, "w4_5+5"));

    // ---------------- reset with valid inputs asserted on every instance
    rst = 1'b1;
    v1 = 1'b1; a1 = 1'b1;  b1 = 1'b1;  c1 = 1'b1;
    v4 = 1'b1; a4 = 4'hF;  b4 = 4'hF;  c4 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(posedge clk);
      #1;
      check_out(1, 1'b0, '0, "reset_w1");
      check_out(4, 1'b0, '0, "reset_w4");
      check_out(8, 1'b0, '0, "reset_w8");
    end
    for (int k = 0; k < 3; k++) held[k] = '0;
    rst = 1'b0;

    // ---------------- table-driven vectors, back to back
    for (int i = 0; i < vecs.size(); i++) begin
      e       = '0;
      e.s     = 32'(vecs[i].exp_s);
      e.c_out = vecs[i].exp_co;
      e.ovf   = vecs[i].exp_ovf;
      apply(vecs[i].w, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].c, e, vecs[i].nm);
    end

    // ---------------- mid-stream reset: 5+5 result just loaded, now reset
    rst = 1'b1;
    apply(4, 1'b0, 8'h0, 8'h0, 1'b0, '0, "mid_rst");
    rst = 1'b0;
    apply(4, 1'b0, 8'h9, 8'h9, 1'b1, '0, "mid_rst_idle");
    e = '0; e.s = 32'h4;
    apply(4, 1'b1, 8'h2, 8'h2, 1'b0, e, "mid_rst_2+2");

    // ---------------- random traffic at WIDTH = 8
    for (int i = 0; i < 1000; i++) begin
      rv = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      apply(8, rv, ra, rb, rc, model(8, ra, rb, rc), "rand_w8");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_full_adder_unit
`default_nettype wire
